regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr_arbiter2.sv | 45 ++++
 rtl/regfile_wb_arbiter.sv | 90 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter slice:
// default widths, architectural register constants and requester ids.
package regfile_wb_arbiter_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned ADDR_W_DEFAULT = 5;

    // Stack-pointer register index.
    localparam int unsigned SP_IDX = 2;

    typedef enum logic {
        REQ_ALU  = 1'b0,
        REQ_LOAD = 1'b1
    } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-input round-robin arbiter with a last-grant pointer
// that advances only when a request is accepted.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic iCLK,
    input  logic iRST,
    input  logic iReq0,
    input  logic iReq1,
    output logic oGnt0,
    output logic oGnt1
);

    req_id_t last_q;
    req_id_t last_d;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            last_q <= REQ_LOAD;
        end else begin
            last_q <= last_d;
        end
    end

    // A grant always coincides with a valid request, so grant == acceptance.
    always_comb begin
        oGnt0  = 1'b0;
        oGnt1  = 1'b0;
        last_d = last_q;
        if (!iRST) begin
            if (iReq0 && (!iReq1 || (last_q == REQ_LOAD))) begin
                oGnt0 = 1'b1;
            end else if (iReq1) begin
                oGnt1 = 1'b1;
            end

            if (oGnt0) begin
                last_d = REQ_ALU;
            end else if (oGnt1) begin
                last_d = REQ_LOAD;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the register file: round-robin grant,
// registered write port, optional pending-write scoreboard (RF_SCOREBOARD_EN).
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq0,
    input  logic [ADDR_W-1:0] iAddr0,
    input  logic [DATA_W-1:0] iData0,
    input  logic              iReq1,
    input  logic [ADDR_W-1:0] iAddr1,
    input  logic [DATA_W-1:0] iData1,
    output logic              oGnt0,
    output logic              oGnt1,
    output logic              oRegWrite,
    output logic [ADDR_W-1:0] oWriteRegister,
    output logic [DATA_W-1:0] oWriteData,
    input  logic              iAlloc,
    input  logic [ADDR_W-1:0] iAllocReg,
    input  logic [ADDR_W-1:0] iRs1,
    input  logic [ADDR_W-1:0] iRs2,
    output logic              oBusy1,
    output logic              oBusy2
);

    rr_arbiter2 u_arb (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iReq0 (iReq0),
        .iReq1 (iReq1),
        .oGnt0 (oGnt0),
        .oGnt1 (oGnt1)
    );

    // x0 writes are accepted and registered but never enable the write.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRegWrite      <= 1'b0;
            oWriteRegister <= '0;
            oWriteData     <= '0;
        end else if (oGnt0) begin
            oRegWrite      <= (iAddr0 != '0);
            oWriteRegister <= iAddr0;
            oWriteData     <= iData0;
        end else if (oGnt1) begin
            oRegWrite      <= (iAddr1 != '0);
            oWriteRegister <= iAddr1;
            oWriteData     <= iData1;
        end else begin
            oRegWrite      <= 1'b0;
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [(2**ADDR_W)-1:0] sb_q;
    logic [(2**ADDR_W)-1:0] sb_d;

    // Clear first, then set, so a same-cycle allocation wins.
    always_comb begin
        sb_d = sb_q;
        if (oRegWrite) begin
            sb_d[oWriteRegister] = 1'b0;
        end
        if (iAlloc && (iAllocReg != '0)) begin
            sb_d[iAllocReg] = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign oBusy1 = sb_q[iRs1];
    assign oBusy2 = sb_q[iRs2];
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{iAlloc, iAllocReg, iRs1, iRs2};
    assign oBusy1 = 1'b0;
    assign oBusy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter (default build and
// RF_SCOREBOARD_EN build).
module tb_regfile_wb_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iReq0 = 1'b0, iReq1 = 1'b0;
    logic [4:0]  iAddr0 = '0, iAddr1 = '0;
    logic [31:0] iData0 = '0, iData1 = '0;
    logic        oGnt0, oGnt1, oRegWrite;
    logic [4:0]  oWriteRegister;
    logic [31:0] oWriteData;
    logic        iAlloc = 1'b0;
    logic [4:0]  iAllocReg = '0, iRs1 = '0, iRs2 = '0;
    logic        oBusy1, oBusy2;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iReq0(iReq0), .iAddr0(iAddr0), .iData0(iData0),
        .iReq1(iReq1), .iAddr1(iAddr1), .iData1(iData1),
        .oGnt0(oGnt0), .oGnt1(oGnt1),
        .oRegWrite(oRegWrite), .oWriteRegister(oWriteRegister), .oWriteData(oWriteData),
        .iAlloc(iAlloc), .iAllocReg(iAllocReg), .iRs1(iRs1), .iRs2(iRs2),
        .oBusy1(oBusy1), .oBusy2(oBusy2)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        string       name;
        logic        r0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        r1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
        logic        rw;
        logic        chk_wd;
        logic [4:0]  wr;
        logic [31:0] wd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(string nm, logic r0, logic [4:0] a0, logic [31:0] d0,
                                logic r1, logic [4:0] a1, logic [31:0] d1,
                                logic g0, logic g1, logic rw, logic chk_wd,
                                logic [4:0] wr, logic [31:0] wd);
        vec_t v;
        v.name = nm; v.r0 = r0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.rw = rw; v.chk_wd = chk_wd;
        v.wr = wr; v.wd = wd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive_reqs(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                              input logic r1, input logic [4:0] a1, input logic [31:0] d1);
        iReq0 = r0; iAddr0 = a0; iData0 = d0;
        iReq1 = r1; iAddr1 = a1; iData1 = d1;
    endtask

    initial begin
        // Pointer starts at LOAD after reset, so contention first goes to ALU.
        vt.push_back(mk("single0",   1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 0, 1, 1, 5, 32'hDEADBEEF));
        vt.push_back(mk("idle_hold", 0, 0, 0,            0, 0, 0,          0, 0, 0, 1, 5, 32'hDEADBEEF));
        vt.push_back(mk("single1",   0, 0, 0,            1, 6, 32'h66,     0, 1, 1, 1, 6, 32'h66));
        vt.push_back(mk("cont_a",    1, 3, 32'h11,       1, 4, 32'h22,     1, 0, 1, 1, 3, 32'h11));
        vt.push_back(mk("cont_b",    1, 3, 32'h11,       1, 4, 32'h22,     0, 1, 1, 1, 4, 32'h22));
        vt.push_back(mk("cont_c",    1, 3, 32'h11,       1, 4, 32'h22,     1, 0, 1, 1, 3, 32'h11));
        vt.push_back(mk("cont_d",    1, 3, 32'h11,       1, 4, 32'h22,     0, 1, 1, 1, 4, 32'h22));
        vt.push_back(mk("x0_write",  0, 0, 0,            1, 0, 32'h1234,   0, 1, 0, 0, 0, 0));
        vt.push_back(mk("single0_b", 1, 5, 32'h55,       0, 0, 0,          1, 0, 1, 1, 5, 32'h55));
        vt.push_back(mk("idle_end",  0, 0, 0,            0, 0, 0,          0, 0, 0, 1, 5, 32'h55));

        // Reset with requests pending: no grants while reset is high.
        drive_reqs(1, 5, 32'hAAAA, 1, 6, 32'hBBBB);
        @(negedge iCLK);
        check("rst_gnt0", {31'b0, oGnt0}, 0);
        check("rst_gnt1", {31'b0, oGnt1}, 0);
        @(posedge iCLK);
        @(negedge iCLK);
        drive_reqs(0, 0, 0, 0, 0, 0);
        #1;
        check("rst_regwrite", {31'b0, oRegWrite}, 0);
        check("rst_wreg", {27'b0, oWriteRegister}, 0);
        check("rst_wdata", oWriteData, 0);
        iRST = 1'b0;

        foreach (vt[i]) begin
            @(negedge iCLK);
            drive_reqs(vt[i].r0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].a1, vt[i].d1);
            #1;
            check({vt[i].name, "_gnt0"}, {31'b0, oGnt0}, {31'b0, vt[i].g0});
            check({vt[i].name, "_gnt1"}, {31'b0, oGnt1}, {31'b0, vt[i].g1});
            @(posedge iCLK);
            #1;
            check({vt[i].name, "_regwrite"}, {31'b0, oRegWrite}, {31'b0, vt[i].rw});
            if (vt[i].chk_wd) begin
                check({vt[i].name, "_wreg"}, {27'b0, oWriteRegister}, {27'b0, vt[i].wr});
                check({vt[i].name, "_wdata"}, oWriteData, vt[i].wd);
            end
        end

        // Reset right after an accepted write: pulse discarded, pointer reset.
        @(negedge iCLK);
        drive_reqs(1, 10, 32'hAA, 0, 0, 0);
        @(posedge iCLK); #1;
        check("pre_rst_regwrite", {31'b0, oRegWrite}, 1);
        @(negedge iCLK);
        iRST = 1'b1;
        drive_reqs(1, 10, 32'hAA, 1, 11, 32'hBB);
        #1;
        check("rst2_gnt0", {31'b0, oGnt0}, 0);
        check("rst2_gnt1", {31'b0, oGnt1}, 0);
        @(posedge iCLK); #1;
        check("rst2_regwrite", {31'b0, oRegWrite}, 0);
        check("rst2_wreg", {27'b0, oWriteRegister}, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        #1;
        check("post_rst_gnt0", {31'b0, oGnt0}, 1);
        check("post_rst_gnt1", {31'b0, oGnt1}, 0);
        @(posedge iCLK); #1;
        check("post_rst_wreg", {27'b0, oWriteRegister}, 10);
        check("post_rst_wdata", oWriteData, 32'hAA);
        @(negedge iCLK);
        drive_reqs(0, 0, 0, 0, 0, 0);
        @(posedge iCLK); #1;
        check("post_rst_idle_regwrite", {31'b0, oRegWrite}, 0);

`ifdef RF_SCOREBOARD_EN
        @(negedge iCLK);
        iAlloc = 1'b1; iAllocReg = 7; iRs1 = 7; iRs2 = 9;
        #1;
        check("sb_busy1_before", {31'b0, oBusy1}, 0);
        @(posedge iCLK); #1;
        check("sb_busy1_set", {31'b0, oBusy1}, 1);
        @(negedge iCLK);
        iAlloc = 1'b0;
        drive_reqs(1, 7, 32'h77, 0, 0, 0);
        @(posedge iCLK); #1;
        check("sb_wr7_regwrite", {31'b0, oRegWrite}, 1);
        check("sb_busy1_during_write", {31'b0, oBusy1}, 1);
        @(negedge iCLK);
        drive_reqs(0, 0, 0, 0, 0, 0);
        @(posedge iCLK); #1;
        check("sb_busy1_cleared", {31'b0, oBusy1}, 0);

        @(negedge iCLK);
        iAlloc = 1'b1; iAllocReg = 9;
        @(posedge iCLK); #1;
        check("sb_busy2_set", {31'b0, oBusy2}, 1);
        @(negedge iCLK);
        iAlloc = 1'b0;
        drive_reqs(1, 9, 32'h99, 0, 0, 0);
        @(posedge iCLK); #1;
        check("sb_wr9_wreg", {27'b0, oWriteRegister}, 9);
        @(negedge iCLK);
        drive_reqs(0, 0, 0, 0, 0, 0);
        iAlloc = 1'b1; iAllocReg = 9;
        @(posedge iCLK); #1;
        check("sb_set_wins", {31'b0, oBusy2}, 1);
        @(negedge iCLK);
        iAlloc = 1'b0;
        @(posedge iCLK); #1;
        check("sb_set_wins_hold", {31'b0, oBusy2}, 1);

        @(negedge iCLK);
        iAlloc = 1'b1; iAllocReg = 0; iRs1 = 0;
        @(posedge iCLK); #1;
        check("sb_x0_never_busy", {31'b0, oBusy1}, 0);
        @(negedge iCLK);
        iAlloc = 1'b0;
`else
        @(negedge iCLK);
        iAlloc = 1'b1; iAllocReg = 7; iRs1 = 7; iRs2 = 7;
        @(posedge iCLK); #1;
        check("nosb_busy1", {31'b0, oBusy1}, 0);
        check("nosb_busy2", {31'b0, oBusy2}, 0);
        @(negedge iCLK);
        iAlloc = 1'b0;
`endif

        @(posedge iCLK); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
